// File: rtl/aer_receiver.sv
// DAVIS240C AER receiver: synchronised 4-phase REQ/ACK capture into a FWFT event FIFO.
// Define AER_TIMESTAMP_EN to attach a free-running TS_W-bit timestamp to every event.
module aer_receiver #(
   parameter int SETTLE_CYC = 2,
   parameter int TIMEOUT    = 1023,
   parameter int FIFO_DEPTH = 8,
   parameter int TS_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_n,
   input  logic [9:0]                    aer,
   output logic                          ack_n,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [9:0]                    ev_addr,
   output logic [TS_W-1:0]               ev_ts,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          err_timeout,
   input  logic                          err_clr
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {IDLE, SETTLE, WAIT_REL, DRAIN} state_e;

   logic [1:0]     sync_q;
   logic           req_s;
   state_e         state_q;
   logic [3:0]     cnt_q;
   logic [15:0]    tmo_q;
   logic           ack_n_q;
   logic           err_q;

   logic [9:0]     mem_addr [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]  level_q, level_d;
   logic           full, push, pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], req_n};
   end
   assign req_s = sync_q[1];

   assign full = (level_q == LW'(FIFO_DEPTH));
   assign push = (state_q == SETTLE) && (cnt_q == 4'(SETTLE_CYC - 1));
   assign pop  = ev_valid && ev_ready;

   // ack_n is registered from the state, so it follows WAIT_REL entry/exit by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         ack_n_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         ack_n_q <= (state_q != WAIT_REL);
         if (err_clr) err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!req_s && !full) begin
                  state_q <= SETTLE;
                  cnt_q   <= '0;
               end
            end
            SETTLE: begin
               if (push) begin
                  state_q <= WAIT_REL;
                  tmo_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            WAIT_REL: begin
               if (req_s) begin
                  state_q <= IDLE;
               end else if (tmo_q == 16'(TIMEOUT - 1)) begin
                  state_q <= DRAIN;
                  err_q   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
            DRAIN:   if (req_s) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: combinational blocks use '=' and assign a default first, so no latch is inferred.
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q <= level_d;
      end
   end

   // NOTE: storage is left unreset; the level counter alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_addr[wr_ptr_q] <= aer;
   end

   assign ev_valid = (level_q != '0);
   assign ev_addr  = ev_valid ? mem_addr[rd_ptr_q] : '0;

`ifdef AER_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] mem_ts [FIFO_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_q + TS_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push) mem_ts[wr_ptr_q] <= ts_q;
   end

   assign ev_ts = ev_valid ? mem_ts[rd_ptr_q] : '0;
`else
   assign ev_ts = '0;
`endif

   assign ack_n       = ack_n_q;
   assign fifo_level  = level_q;
   assign err_timeout = err_q;

endmodule
